// File: rtl/btle_pkg.sv
// Shared BTLE constants and types for the transmit-chain CRC blocks.
package btle_pkg;

  localparam int          CRC_LEN       = 24;
  // Feedback taps of x^24+x^10+x^9+x^6+x^4+x^3+x+1 (bits 0,1,3,4,6,9,10).
  localparam logic [23:0] CRC_POLY_TAPS = 24'h00065B;
  // Preset used on advertising channels.
  localparam logic [23:0] ADV_CRC_INIT  = 24'h555555;

  typedef enum logic {
    PASS    = 1'b0,
    CRC_OUT = 1'b1
  } crc_state_e;

endpackage

// File: rtl/btle_crc24_lfsr.sv
// Combinational one-bit step of the BLE CRC-24 LFSR: (s, d) -> s_next.
module btle_crc24_lfsr
  import btle_pkg::*;
(
  input  logic [CRC_LEN-1:0] s,
  input  logic               d,
  output logic [CRC_LEN-1:0] s_next
);

  logic fb;

  assign fb = s[CRC_LEN-1] ^ d;

  // Shift left and fold the feedback into the tap positions; bit 0 of the
  // tap mask places fb into the vacated LSB.
  assign s_next = {s[CRC_LEN-2:0], 1'b0} ^ ({CRC_LEN{fb}} & CRC_POLY_TAPS);

endmodule

// File: rtl/btle_crc24_appender.sv
// Bit-serial BLE CRC-24 appender: passes info bits through with one cycle
// of latency while accumulating the CRC, then emits the 24 CRC bits
// MSB-first at the PHY bit rate and flags the last one.
module btle_crc24_appender
  import btle_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int CLK_PER_BIT         = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           info_bit,
  input  logic                           info_bit_valid,
  input  logic                           info_bit_valid_last,
  output logic                           info_bit_after_crc24,
  output logic                           info_bit_after_crc24_valid,
  output logic                           info_bit_after_crc24_valid_last
);

  localparam int                PACE_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [PACE_W-1:0] PACE_MAX = PACE_W'(CLK_PER_BIT - 1);
  localparam int                EMIT_W   = $clog2(CRC_LEN);
  localparam logic [EMIT_W-1:0] EMIT_MAX = EMIT_W'(CRC_LEN - 1);

  crc_state_e                     state_q, state_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [PACE_W-1:0]              pace_q, pace_d;
  logic [EMIT_W-1:0]              emit_q, emit_d;
  logic                           bit_q, bit_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;

  btle_crc24_lfsr u_lfsr (
    .s      (lfsr_q),
    .d      (info_bit),
    .s_next (lfsr_step)
  );

  // Next-state, LFSR, pacing and output decode for both phases of a frame.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    pace_d  = pace_q;
    emit_d  = emit_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      PASS: begin
        if (info_bit_valid) begin
          bit_d   = info_bit;
          valid_d = 1'b1;
          lfsr_d  = lfsr_step;
          if (info_bit_valid_last) begin
            state_d = CRC_OUT;
            pace_d  = '0;
            emit_d  = '0;
          end
        end
        // The preset wins over a coincident bit: the bit still passes
        // through but is not folded into the CRC.
        if (crc_state_init_bit_load) begin
          lfsr_d = crc_state_init_bit;
        end
      end

      CRC_OUT: begin
        if (pace_q == PACE_MAX) begin
          pace_d  = '0;
          bit_d   = lfsr_q[CRC_STATE_BIT_WIDTH-1];
          valid_d = 1'b1;
          lfsr_d  = {lfsr_q[CRC_STATE_BIT_WIDTH-2:0], 1'b0};
          emit_d  = emit_q + EMIT_W'(1);
          if (emit_q == EMIT_MAX) begin
            last_d  = 1'b1;
            emit_d  = '0;
            state_d = PASS;
          end
        end else begin
          pace_d = pace_q + PACE_W'(1);
        end
      end

      default: state_d = PASS;
    endcase
  end

  // State and registered outputs; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
      lfsr_q  <= '0;
      pace_q  <= '0;
      emit_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pace_q  <= pace_d;
      emit_q  <= emit_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign info_bit_after_crc24            = bit_q;
  assign info_bit_after_crc24_valid      = valid_q;
  assign info_bit_after_crc24_valid_last = last_q;

endmodule

// File: tb/tb_btle_crc24_appender.sv
// Self-checking bench for btle_crc24_appender: random frames checked
// against a queue-based reference model of the pass-through and CRC rules.
module tb_btle_crc24_appender;
  import btle_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] init_val = '0;
  logic        init_load = 1'b0;
  logic        info_bit = 1'b0;
  logic        info_valid = 1'b0;
  logic        info_last = 1'b0;
  logic        out_bit, out_valid, out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stray_last = 0;

  typedef struct {
    logic b;
    logic l;
    int   c;
  } cap_t;

  cap_t caps[$];
  logic stim[$];

  btle_crc24_appender #(
    .CRC_STATE_BIT_WIDTH (24),
    .CLK_PER_BIT         (CPB)
  ) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .crc_state_init_bit              (init_val),
    .crc_state_init_bit_load         (init_load),
    .info_bit                        (info_bit),
    .info_bit_valid                  (info_valid),
    .info_bit_valid_last             (info_last),
    .info_bit_after_crc24            (out_bit),
    .info_bit_after_crc24_valid      (out_valid),
    .info_bit_after_crc24_valid_last (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every valid output with the edge it followed.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) caps.push_back('{b: out_bit, l: out_last, c: cyc});
    if (out_last === 1'b1 && out_valid !== 1'b1) stray_last++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference CRC step written straight from the rule: shift fb in at the
  // LSB, then toggle bits 1,3,4,6,9,10 when fb is set.
  function automatic logic [23:0] crc_step(input logic [23:0] s, input logic d);
    logic fb;
    int   taps[6];
    fb   = s[23] ^ d;
    taps = '{1, 3, 4, 6, 9, 10};
    s    = {s[22:0], fb};
    for (int k = 0; k < 6; k++) s[taps[k]] = s[taps[k]] ^ fb;
    return s;
  endfunction

  task automatic push_lsb_first(input logic [31:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) stim.push_back(v[i]);
  endtask

  // Sends stim[] as one frame and checks every output bit, its flag and its
  // timing against the model. collide: preset load rides on the first bit.
  // noise: random valid/load activity while the CRC is being emitted.
  task automatic run_frame(input string name, input logic [23:0] init,
                           input bit do_load, input int gap,
                           input bit collide, input bit noise);
    int          in_edge[$];
    int          n;
    int          waited;
    logic [23:0] crc;
    int          exp_c;
    logic        exp_b, exp_l;
    n = stim.size();
    caps.delete();
    if (do_load && !collide) begin
      init_val  = init;
      init_load = 1'b1;
      step();
      init_load = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      info_bit   = stim[i];
      info_valid = 1'b1;
      info_last  = (i == n - 1);
      if (collide && i == 0) begin
        init_val  = init;
        init_load = 1'b1;
      end
      in_edge.push_back(cyc + 1);
      step();
      info_valid = 1'b0;
      info_last  = 1'b0;
      init_load  = 1'b0;
      repeat (gap - 1) step();
    end
    if (noise) begin
      for (int k = 0; k < 370; k++) begin
        info_bit   = 1'($urandom_range(1, 0));
        info_valid = 1'($urandom_range(1, 0));
        info_last  = 1'($urandom_range(1, 0));
        init_load  = 1'($urandom_range(1, 0));
        init_val   = 24'($urandom());
        step();
      end
      info_valid = 1'b0;
      info_last  = 1'b0;
      init_load  = 1'b0;
    end
    waited = 0;
    while (!(caps.size() > 0 && caps[caps.size()-1].l === 1'b1) && waited < 600) begin
      step();
      waited++;
    end
    total++;
    if (waited >= 600) begin
      bad++;
      $display("FAIL %s timeout: no valid_last seen, got %0d outputs", name, caps.size());
    end
    repeat (20) step();

    crc = init;
    for (int i = (collide ? 1 : 0); i < n; i++) crc = crc_step(crc, stim[i]);

    total++;
    if (caps.size() != n + 24) begin
      bad++;
      $display("FAIL %s count: got %0d outputs, expected %0d", name, caps.size(), n + 24);
    end
    for (int i = 0; i < caps.size() && i < n + 24; i++) begin
      exp_b = (i < n) ? stim[i] : crc[23 - (i - n)];
      exp_l = (i == n + 23);
      exp_c = (i < n) ? in_edge[i] : in_edge[n-1] + CPB * (i - n + 1);
      total++;
      if (caps[i].b !== exp_b || caps[i].l !== exp_l || caps[i].c != exp_c) begin
        bad++;
        $display("FAIL %s out[%0d]: got bit=%b last=%b edge=%0d, expected bit=%b last=%b edge=%0d",
                 name, i, caps[i].b, caps[i].l, caps[i].c, exp_b, exp_l, exp_c);
      end
    end
    total++;
    if (stray_last != 0) begin
      bad++;
      $display("FAIL %s stray_last: got %0d, expected 0", name, stray_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({out_bit, out_valid, out_last} !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: got %b, expected 000", {out_bit, out_valid, out_last});
    end
    rst_n = 1'b1;
    step();
    // Get the outputs non-zero, then reset asynchronously mid-cycle.
    info_bit   = 1'b1;
    info_valid = 1'b1;
    step();
    info_valid = 1'b0;
    total++;
    if ({out_bit, out_valid, out_last} !== 3'b110) begin
      bad++;
      $display("FAIL pre_reset_pass: got %b, expected 110", {out_bit, out_valid, out_last});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_bit, out_valid, out_last} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset: got %b, expected 000", {out_bit, out_valid, out_last});
    end
    step();
    rst_n = 1'b1;
    step();
    // LFSR must be zero after reset: a frame without a preset load uses 0.
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(1'($urandom_range(1, 0)));
    run_frame("post_reset_zero_lfsr", 24'h000000, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_single_bit();
    logic [23:0] got_crc;
    stim.delete();
    stim.push_back(1'b1);
    run_frame("single_bit", 24'h000000, 1'b1, 1, 1'b0, 1'b0);
    got_crc = '0;
    for (int i = 1; i < caps.size() && i <= 24; i++) got_crc = {got_crc[22:0], caps[i].b};
    total++;
    if (got_crc !== 24'h00065B) begin
      bad++;
      $display("FAIL single_bit_crc: got %06h, expected 00065b", got_crc);
    end
  endtask

  task automatic test_zero_adv();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(1'b0);
    run_frame("zero_adv", ADV_CRC_INIT, 1'b1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_full_packet();
    stim.delete();
    push_lsb_first(32'h000000AA, 8);
    push_lsb_first(32'h8E89BED6, 32);
    push_lsb_first(32'($urandom_range(16'hFFFF, 0)), 16);
    push_lsb_first($urandom(), 32);
    push_lsb_first(32'($urandom_range(16'hFFFF, 0)), 16);
    run_frame("full_packet", ADV_CRC_INIT, 1'b1, CPB, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(1'($urandom_range(1, 0)));
    run_frame("ignored_in_crc_out", 24'($urandom()), 1'b1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_load_collision();
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(1'($urandom_range(1, 0)));
    run_frame("load_collision", 24'($urandom()), 1'b1, 1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      stim.delete();
      for (int i = 0; i < 1 + int'($urandom_range(30, 0)); i++)
        stim.push_back(1'($urandom_range(1, 0)));
      run_frame("back_to_back", 24'($urandom()), 1'b1, 1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    init_val  = ADV_CRC_INIT;
    init_load = 1'b1;
    step();
    init_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      info_bit   = 1'($urandom_range(1, 0));
      info_valid = 1'b1;
      info_last  = (i == 4);
      step();
    end
    info_valid = 1'b0;
    info_last  = 1'b0;
    repeat (CPB * 3 + 3) step();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_bit, out_valid, out_last} !== 3'b000) begin
      bad++;
      $display("FAIL mid_frame_reset: got %b, expected 000", {out_bit, out_valid, out_last});
    end
    step();
    rst_n = 1'b1;
    caps.delete();
    repeat (CPB * 26) step();
    total++;
    if (caps.size() != 0) begin
      bad++;
      $display("FAIL mid_frame_abort: got %0d outputs after reset, expected 0", caps.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_zero_adv();
    test_full_packet();
    test_ignored_inputs();
    test_load_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btle_crc24_appender.md
Name: btle_crc24_appender

Overview:
- Bit-serial BLE CRC-24 generator/appender in the BTLE transmit chain, between the PDU bit serializer and the whitening/scrambler stage.
- Passes each info bit (preamble, access address, PDU) through with one cycle of latency and updates a 24-bit LFSR.
- After the last info bit, emits the 24 CRC bits MSB-first, paced at the PHY bit rate, and flags the final one.

Parameters:
- CRC_STATE_BIT_WIDTH, 24: LFSR width; only 24 is supported.
- CLK_PER_BIT, 16: clock cycles between consecutive appended CRC bits (16 MHz clk, 1 Mbit/s PHY).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- crc_state_init_bit  in  24  LFSR preset value (0x555555 for advertising channels).
- crc_state_init_bit_load  in  1  pulse; loads the preset.
- info_bit  in  1  input bit, LSB-first order as produced upstream.
- info_bit_valid  in  1  qualifies info_bit for one cycle.
- info_bit_valid_last  in  1  high together with info_bit_valid on the final info bit.
- info_bit_after_crc24  out  1  output bit.
- info_bit_after_crc24_valid  out  1  output bit qualifier.
- info_bit_after_crc24_valid_last  out  1  high on the final appended CRC bit.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - LFSR is 0, bit counter is 0, state is PASS.
- LFSR s[23:0] update for each accepted input bit d:
  - fb = s[23]^d.
  - s_next = {s[22:0], fb}, then XOR fb into bits 1, 3, 4, 6, 9 and 10.
  - This implements x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- Preset load: crc_state_init_bit_load=1 sets s <= crc_state_init_bit (bit 0 = LSB) on the next edge.
  - The load has priority over a simultaneous info_bit_valid in PASS; that bit is still passed through but does not update s.
  - A load during CRC_OUT is ignored.
- State PASS:
  - On info_bit_valid=1, register info_bit onto info_bit_after_crc24, set info_bit_after_crc24_valid=1 for exactly one cycle, and update s.
  - Latency from input to output is 1 cycle.
  - If info_bit_valid_last is also 1, go to CRC_OUT with the emit counter at 0 and the pacing counter at 0. That bit's output has valid_last=0.
  - info_bit_valid_last without info_bit_valid is ignored.
- State CRC_OUT:
  - Emit s[23], s[22], ..., s[0], in that order.
  - First CRC bit: valid is asserted CLK_PER_BIT cycles after the last info bit's output valid.
  - Following CRC bits: one every CLK_PER_BIT cycles, valid high for 1 cycle each.
  - Emission is implemented by shifting s left, with 0 entering the LSB.
  - On the 24th bit, valid_last=1 together with valid; the next state is PASS.
  - info_bit_valid is ignored in CRC_OUT (no pass-through, no LFSR update).
- After a frame, s holds the shifted-out value, 0. The user must reload the preset before the next frame.
- Outside valid cycles, info_bit_after_crc24 holds its last value; valid and valid_last are 0.
- Reset mid-frame aborts immediately to the reset state; no partial CRC is emitted.
- A packet of any length ≥1 bit is supported. No internal limit on the bit count in PASS.

Decomposition:
- Shared package btle_pkg:
  - CRC_POLY_TAPS = 24'h00065B (feedback taps for bits 0,1,3,4,6,9,10).
  - ADV_CRC_INIT = 24'h555555.
  - CRC_LEN = 24.
  - State enum {PASS, CRC_OUT}.
- One sub-module, btle_crc24_lfsr: combinational next-state function (s, d) -> s_next.
- Pacing, counters and output muxing stay in the top level.

Test Plan:
- Reset values: rst_n=0 mid-stream -> all outputs 0 immediately. After release, PASS with s=0.
- Single bit: load init 0x000000, then one info bit 1 with valid and valid_last.
  - Output 1 appears one cycle later.
  - Then 24 bits at 16-cycle spacing: thirteen 0s followed by 1,1,0,0,1,0,1,1,0,1,1.
  - valid_last is high on the 24th bit only.
- Zero input, advertising init: load 0x555555 and send eight 0 bits.
  - Output bits equal input bits, 1 cycle delayed.
  - Appended CRC matches a software LFSR model with the same taps.
- Full advertising packet: 40-bit preamble/AA plus 2-byte header plus 6-byte payload, init 0x555555, bits every 16 cycles.
  - 104 pass-through bits, then 24 CRC bits equal to the golden model.
  - Exactly one valid_last.
- Ignored inputs:
  - info_bit_valid pulses during CRC_OUT -> no extra output valids; CRC unchanged.
  - Load during CRC_OUT -> ignored.
- Load collision: load and info_bit_valid in the same cycle -> bit is passed through; s equals the preset afterwards.
